// File: rtl/stage8_pkg.sv
// Shared types and defaults for the stage-8 window sequencer.
// Holds the controller state encoding and the default feature-map geometry.
package stage8_pkg;

   localparam int FMAP_W_DEF = 8;
   localparam int FMAP_H_DEF = 8;
   localparam int KERNEL_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   typedef logic [$clog2(FMAP_W_DEF)-1:0] win_col_t;
   typedef logic [$clog2(FMAP_H_DEF)-1:0] win_row_t;

endpackage

// File: rtl/stage8_window_ctrl_pos_cnt.sv
// Row/column position of the next pixel to be accepted into the line buffer.
// Advances only on accepted pixels; flags the final pixel of the map.
module stage8_pos_cnt
   import stage8_pkg::*;
#(
   parameter int FMAP_W = FMAP_W_DEF,
   parameter int FMAP_H = FMAP_H_DEF,
   parameter int CW     = $clog2(FMAP_W),
   parameter int RW     = $clog2(FMAP_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);

   logic [CW-1:0] col_d, col_q;
   logic [RW-1:0] row_d, row_q;

   // next position: clear on map start, advance with wrap on each accept
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr) begin
         col_d = {CW{1'b0}};
         row_d = {RW{1'b0}};
      end else if (en) begin
         if (col_q == CW'(FMAP_W - 1)) begin
            col_d = {CW{1'b0}};
            if (row_q == RW'(FMAP_H - 1)) begin
               row_d = {RW{1'b0}};
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
            row_d = row_q;
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // position registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= {CW{1'b0}};
         row_q <= {RW{1'b0}};
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col  = col_q;
   assign row  = row_q;
   assign last = (col_q == CW'(FMAP_W - 1)) && (row_q == RW'(FMAP_H - 1));

endmodule

// File: rtl/stage8_window_ctrl.sv
// Stage-8 line-buffer sequencer: gates shifting on accepted pixels and
// presents each complete KxK window position to the convolution PE.
module stage8_window_ctrl
   import stage8_pkg::*;
#(
   parameter int FMAP_W = FMAP_W_DEF,
   parameter int FMAP_H = FMAP_H_DEF,
   parameter int KERNEL = KERNEL_DEF,
   parameter int CW     = $clog2(FMAP_W),
   parameter int RW     = $clog2(FMAP_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          shift_en,
   output logic          win_valid,
   input  logic          win_ready,
   output logic [RW-1:0] win_row,
   output logic [CW-1:0] win_col,
   output logic          busy,
   output logic          done
);

   state_e        state_d, state_q;
   logic          win_valid_d, win_valid_q;
   logic [RW-1:0] win_row_d, win_row_q;
   logic [CW-1:0] win_col_d, win_col_q;
   logic          busy_d, busy_q;
   logic          done_d, done_q;

   logic          in_ready_s, shift_en_s, win_hit_s, clr_s, last_s;
   logic [CW-1:0] col_s;
   logic [RW-1:0] row_s;

   stage8_pos_cnt #(
      .FMAP_W (FMAP_W),
      .FMAP_H (FMAP_H),
      .CW     (CW),
      .RW     (RW)
   ) u_pos_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_s),
      .en   (shift_en_s),
      .col  (col_s),
      .row  (row_s),
      .last (last_s)
   );

   // handshake: a held window blocks the stream so no window is ever dropped
   always_comb begin
      in_ready_s = (state_q == ST_STREAM) && (!win_valid_q || win_ready);
      shift_en_s = in_valid && in_ready_s;
      win_hit_s  = shift_en_s && (row_s >= RW'(KERNEL - 1)) && (col_s >= CW'(KERNEL - 1));
   end

   // next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      win_valid_d = win_valid_q;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      clr_s       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_STREAM;
               busy_d  = 1'b1;
               clr_s   = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (win_hit_s) begin
               win_valid_d = 1'b1;
               win_row_d   = row_s - RW'(KERNEL - 1);
               win_col_d   = col_s - CW'(KERNEL - 1);
            end else if (win_ready) begin
               win_valid_d = 1'b0;
            end else begin
               win_valid_d = win_valid_q;
            end
            if (shift_en_s && last_s) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_FLUSH: begin
            if (!win_valid_q || win_ready) begin
               state_d     = ST_DONE;
               win_valid_d = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            win_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // controller state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         win_valid_q <= 1'b0;
         win_row_q   <= {RW{1'b0}};
         win_col_q   <= {CW{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_valid_q <= win_valid_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign shift_en  = shift_en_s;
   assign win_valid = win_valid_q;
   assign win_row   = win_row_q;
   assign win_col   = win_col_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_stage8_window_ctrl.sv
// Self-checking bench for stage8_window_ctrl: directed and randomized maps
// compared against a pixel-index/window-queue reference model.
module tb_stage8_window_ctrl;

   localparam int W = 8;
   localparam int H = 8;
   localparam int K = 3;
   localparam int NWIN = (H - K + 1) * (W - K + 1);

   logic       clk = 1'b0;
   logic       rst, start, in_valid, win_ready;
   logic       in_ready, shift_en, win_valid, busy, done;
   logic [2:0] win_row, win_col;

   int n_vec = 0;
   int n_err = 0;

   stage8_window_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .shift_en  (shift_en),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_row   (win_row),
      .win_col   (win_col),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_shift_en"}, shift_en, 0);
      chk({tag, "_win_valid"}, win_valid, 0);
      chk({tag, "_win_row"}, win_row, 0);
      chk({tag, "_win_col"}, win_col, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // mode 0: steady flow, 1: backpressure at (3,4), 2: in_valid toggling,
   // 3: random + start pulses while busy and in the done cycle, 4: random
   task automatic run_map(input int mode, input int abort_at);
      int wq_r[$];
      int wq_c[$];
      int acc = 0, consumed = 0, cyc = 0, hold_cnt = 0;
      bit prev_hit = 0, prev_wv = 0, prev_wr = 0, prev_last = 0;
      bit exp_wv, exp_ir, exp_done, exp_shift, fin = 0, seen_first = 0;
      for (int r = K - 1; r < H; r++)
         for (int c = K - 1; c < W; c++) begin
            wq_r.push_back(r - (K - 1));
            wq_c.push_back(c - (K - 1));
         end

      start = 1'b1;
      in_valid = 1'($urandom % 2);
      win_ready = 1'($urandom % 2);
      #3;
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_win_valid", win_valid, 0);
      @(posedge clk); #1;
      start = 1'b0;

      while (!fin && cyc < 3000) begin
         exp_wv   = prev_hit || (prev_wv && !prev_wr);
         exp_done = prev_last;
         if (abort_at > 0 && acc == abort_at) begin
            rst = 1'b1;
            #1;
            chk_zero_outputs("abort_rst");
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         case (mode)
            1: begin
               in_valid = 1'b1;
               if (exp_wv && wq_r.size() > 0 && wq_r[0] == 3 && wq_c[0] == 4 && hold_cnt < 5) begin
                  win_ready = 1'b0;
                  hold_cnt++;
               end else begin
                  win_ready = 1'b1;
               end
            end
            2: begin
               in_valid  = 1'(cyc % 2 == 0);
               win_ready = 1'b1;
            end
            3, 4: begin
               in_valid  = ($urandom % 4) != 0;
               win_ready = ($urandom % 3) != 0;
            end
            default: begin
               in_valid  = 1'b1;
               win_ready = 1'b1;
            end
         endcase
         start = (mode == 3 && (acc == 35 || exp_done)) ? 1'b1 : 1'b0;
         #3;
         exp_ir    = (acc < W * H) && !exp_done && (!exp_wv || win_ready);
         exp_shift = in_valid && exp_ir;
         chk("win_valid", win_valid, exp_wv);
         chk("in_ready", in_ready, exp_ir);
         chk("shift_en", shift_en, exp_shift);
         chk("done", done, exp_done);
         chk("busy", busy, !exp_done);
         if (exp_wv) begin
            if (wq_r.size() == 0) begin
               chk("win_extra", 1, 0);
            end else begin
               chk("win_row", win_row, wq_r[0]);
               chk("win_col", win_col, wq_c[0]);
            end
            if (mode == 0 && !seen_first) begin
               chk("first_win_accepts", acc, 19);
               seen_first = 1;
            end
         end
         prev_hit = exp_shift && (acc / W >= K - 1) && (acc % W >= K - 1);
         if (exp_shift) acc++;
         prev_last = 0;
         if (exp_wv && win_ready && wq_r.size() > 0) begin
            void'(wq_r.pop_front());
            void'(wq_c.pop_front());
            consumed++;
            prev_last = (consumed == NWIN);
         end
         prev_wv = exp_wv;
         prev_wr = win_ready;
         if (exp_done) fin = 1;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      if (!fin) chk("map_timeout", 0, 1);
      chk("accept_count", acc, W * H);
      chk("window_count", consumed, NWIN);
      #3;
      chk("post_done_busy", busy, 0);
      chk("post_done_in_ready", in_ready, 0);
      chk("post_done_done", done, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      win_ready = 1'b0;
      #2;
      chk_zero_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      run_map(0, 0);
      run_map(1, 0);
      run_map(2, 0);
      run_map(3, 0);
      run_map(4, 30);
      run_map(4, 0);
      run_map(4, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stage8_window_ctrl.md
Name: stage8_window_ctrl

Overview:
- Sequencer for the stage-8 line buffer and its 3x3 window register: gates line-buffer shifting on accepted pixels, tracks row/column position and flags complete KxK windows to the layer-6 convolution PE.
- Sits between the upstream pixel stream (valid/ready) and the PE window port (valid/ready); holds the line buffer frozen under backpressure or input gaps.
- One feature map per start pulse; done pulse when the last window is consumed.

Parameters:
- FMAP_W, 8, feature-map width in pixels (line-buffer depth is FMAP_W-2 plus window taps)
- FMAP_H, 8, feature-map height in rows
- KERNEL, 3, window size; windows exist for row>=KERNEL-1 and col>=KERNEL-1
- CW, $clog2(FMAP_W), column counter width
- RW, $clog2(FMAP_H), row counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse, begins one feature map; ignored unless IDLE
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  controller accepts pixel this cycle
- shift_en  out  1  line buffer / window register shift enable, = in_valid & in_ready
- win_valid  out  1  window at PE port complete and valid
- win_ready  in  1  PE consumes window
- win_row  out  RW  output row of presented window (row-(KERNEL-1))
- win_col  out  CW  output column of presented window (col-(KERNEL-1))
- busy  out  1  high from start acceptance until done
- done  out  1  single-cycle pulse, map finished

Behaviour:
- Reset: state IDLE; row, col = 0; in_ready, win_valid, busy, done = 0; win_row, win_col = 0. Reset mid-map abandons the map immediately; no done pulse.
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE: in_ready=0. start -> STREAM, busy=1, row=col=0.
- STREAM: in_ready = !win_valid | win_ready. On accept (shift_en), col increments; at col==FMAP_W-1, col wraps to 0 and row increments. Accepting pixel (row=FMAP_H-1, col=FMAP_W-1) -> FLUSH.
- Window flag: on an accept with row>=KERNEL-1 and col>=KERNEL-1, the next cycle win_valid=1 with win_row/win_col latched from that accept. Latency 1 cycle, aligned with line-buffer output after the same edge.
- win_valid clears on win_ready unless a new qualifying accept occurs in the same cycle, in which case it stays high with updated coordinates (back-to-back, 1 window/cycle).
- Backpressure: win_valid & !win_ready -> in_ready=0, shift_en=0, win_* held stable. No window lost or duplicated.
- in_valid low: shift_en=0, counters and line buffer hold.
- FLUSH: in_ready=0; once win_valid is low or win_ready=1 -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE. A start in the DONE cycle is ignored.
- Total windows per map = (FMAP_H-KERNEL+1)*(FMAP_W-KERNEL+1); accepted pixels = FMAP_H*FMAP_W exactly.
- Start while busy: ignored, no counter effect.

Decomposition:
- Shared package stage8_pkg: state enum (IDLE, STREAM, FLUSH, DONE), FMAP_W/FMAP_H/KERNEL defaults, win_row/win_col typedefs.
- One sub-module: stage8_pos_cnt (col/row counter with wrap, enable = shift_en, last-pixel flag). FSM and window flag stay in top.
- The line buffer itself is a separate existing stage with added shift enable; not instantiated here.

Test Plan:
- 8x8, in_valid=1 constantly, win_ready=1: first win_valid the cycle after the 19th accept (row2,col2) with win_row=0, win_col=0; 36 windows total; done 1 cycle after the 64th accept's window.
- win_ready held low 5 cycles at window (3,4): in_ready=0, shift_en=0, win_row=3/win_col=4 stable all 5 cycles; resume yields (3,5) next; count still 36.
- in_valid toggling every other cycle: shift_en only on valid cycles; window sequence and count identical to the first scenario.
- start pulsed while busy mid-row 4: no reset of counters, single done at end.
- rst asserted at accept 30, then new start: outputs zero immediately; new map produces exactly 36 windows starting at (0,0).
- Row wrap check: the accept at col=7 sets col=0, row+1; no win_valid for col 0 and 1 accepts in any row.
